// File: rtl/usb_link_arbiter.sv
// Routes the single app buffer interface to the SuperSpeed or High-Speed core.
// Debounces link status and drains pending commit/arm handshakes before a switchover.
module usb_link_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 8,
  parameter int LEN_W        = 10,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int DRAIN_TO     = 4096,
  parameter int PREFER_SS    = 1
) (
  input  logic              ext_clk,
  input  logic              reset,
  input  logic              ss_connected,
  input  logic              hs_connected,
  input  logic [ADDR_W-1:0] buf_in_addr,
  input  logic [DATA_W-1:0] buf_in_data,
  input  logic              buf_in_wren,
  input  logic              buf_in_commit,
  input  logic [LEN_W-1:0]  buf_in_commit_len,
  output logic              buf_in_ready,
  output logic              buf_in_commit_ack,
  input  logic [ADDR_W-1:0] buf_out_addr,
  input  logic              buf_out_arm,
  output logic [DATA_W-1:0] buf_out_q,
  output logic [LEN_W-1:0]  buf_out_len,
  output logic              buf_out_hasdata,
  output logic              buf_out_arm_ack,
  output logic              vend_req_act,
  output logic [7:0]        vend_req_request,
  output logic [15:0]       vend_req_val,
  output logic [ADDR_W-1:0] ss_buf_in_addr,
  output logic [DATA_W-1:0] ss_buf_in_data,
  output logic              ss_buf_in_wren,
  output logic              ss_buf_in_commit,
  output logic [LEN_W-1:0]  ss_buf_in_commit_len,
  output logic [ADDR_W-1:0] hs_buf_in_addr,
  output logic [DATA_W-1:0] hs_buf_in_data,
  output logic              hs_buf_in_wren,
  output logic              hs_buf_in_commit,
  output logic [LEN_W-1:0]  hs_buf_in_commit_len,
  output logic [ADDR_W-1:0] ss_buf_out_addr,
  output logic [ADDR_W-1:0] hs_buf_out_addr,
  output logic              ss_buf_out_arm,
  output logic              hs_buf_out_arm,
  input  logic              ss_buf_in_ready,
  input  logic              ss_buf_in_commit_ack,
  input  logic [DATA_W-1:0] ss_buf_out_q,
  input  logic [LEN_W-1:0]  ss_buf_out_len,
  input  logic              ss_buf_out_hasdata,
  input  logic              ss_buf_out_arm_ack,
  input  logic              ss_vend_req_act,
  input  logic [7:0]        ss_vend_req_request,
  input  logic [15:0]       ss_vend_req_val,
  input  logic              hs_buf_in_ready,
  input  logic              hs_buf_in_commit_ack,
  input  logic [DATA_W-1:0] hs_buf_out_q,
  input  logic [LEN_W-1:0]  hs_buf_out_len,
  input  logic              hs_buf_out_hasdata,
  input  logic              hs_buf_out_arm_ack,
  input  logic              hs_vend_req_act,
  input  logic [7:0]        hs_vend_req_request,
  input  logic [15:0]       hs_vend_req_val,
  output logic [1:0]        link_sel,
  output logic              link_switch,
  output logic              xfer_abort
);
  typedef enum logic [1:0] {IDLE, ACT_HS, ACT_SS, DRAIN} state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HS   = 2'b01;
  localparam logic [1:0] SEL_SS   = 2'b10;
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TW = $clog2(DRAIN_TO);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);
  localparam logic [TW-1:0] T_MAX   = TW'(DRAIN_TO - 1);

  state_t        state_q;
  logic [1:0]    tgt_q;
  logic [1:0]    link_sel_q;
  logic          link_switch_q;
  logic          xfer_abort_q;
  logic [TW-1:0] timer_q;
  logic          cpend_q, apend_q;
  logic          cpend_d, apend_d;
  logic [CW-1:0] ss_cnt_q, ss_cnt_d, hs_cnt_q, hs_cnt_d;
  logic          ss_qual_q, hs_qual_q;
  logic          sel_ss, sel_hs, routed, lost, old_qual;
  state_t        tgt_state;

  assign link_sel    = link_sel_q;
  assign link_switch = link_switch_q;
  assign xfer_abort  = xfer_abort_q;

  always_comb begin
    ss_cnt_d = '0;
    hs_cnt_d = '0;
    if (ss_connected)
      ss_cnt_d = (ss_cnt_q == CNT_MAX) ? CNT_MAX : ss_cnt_q + 1'b1;
    if (hs_connected)
      hs_cnt_d = (hs_cnt_q == CNT_MAX) ? CNT_MAX : hs_cnt_q + 1'b1;
  end

  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      ss_cnt_q  <= '0;
      hs_cnt_q  <= '0;
      ss_qual_q <= 1'b0;
      hs_qual_q <= 1'b0;
    end else begin
      ss_cnt_q  <= ss_cnt_d;
      hs_cnt_q  <= hs_cnt_d;
      ss_qual_q <= (ss_cnt_d == CNT_MAX);
      hs_qual_q <= (hs_cnt_d == CNT_MAX);
    end
  end

  assign sel_ss = (link_sel_q == SEL_SS);
  assign sel_hs = (link_sel_q == SEL_HS);
  assign routed = sel_ss | sel_hs;

  assign ss_buf_in_addr       = sel_ss ? buf_in_addr : '0;
  assign ss_buf_in_data       = sel_ss ? buf_in_data : '0;
  assign ss_buf_in_wren       = sel_ss & buf_in_wren;
  assign ss_buf_in_commit     = sel_ss & buf_in_commit;
  assign ss_buf_in_commit_len = sel_ss ? buf_in_commit_len : '0;
  assign ss_buf_out_addr      = sel_ss ? buf_out_addr : '0;
  assign ss_buf_out_arm       = sel_ss & buf_out_arm;
  assign hs_buf_in_addr       = sel_hs ? buf_in_addr : '0;
  assign hs_buf_in_data       = sel_hs ? buf_in_data : '0;
  assign hs_buf_in_wren       = sel_hs & buf_in_wren;
  assign hs_buf_in_commit     = sel_hs & buf_in_commit;
  assign hs_buf_in_commit_len = sel_hs ? buf_in_commit_len : '0;
  assign hs_buf_out_addr      = sel_hs ? buf_out_addr : '0;
  assign hs_buf_out_arm       = sel_hs & buf_out_arm;

  always_comb begin
    buf_in_ready      = 1'b0;
    buf_in_commit_ack = 1'b0;
    buf_out_q         = '0;
    buf_out_len       = '0;
    buf_out_hasdata   = 1'b0;
    buf_out_arm_ack   = 1'b0;
    vend_req_act      = 1'b0;
    vend_req_request  = '0;
    vend_req_val      = '0;
    unique case (1'b1)
      sel_ss: begin
        buf_in_ready      = ss_buf_in_ready;
        buf_in_commit_ack = ss_buf_in_commit_ack;
        buf_out_q         = ss_buf_out_q;
        buf_out_len       = ss_buf_out_len;
        buf_out_hasdata   = ss_buf_out_hasdata;
        buf_out_arm_ack   = ss_buf_out_arm_ack;
        vend_req_act      = ss_vend_req_act;
        vend_req_request  = ss_vend_req_request;
        vend_req_val      = ss_vend_req_val;
      end
      sel_hs: begin
        buf_in_ready      = hs_buf_in_ready;
        buf_in_commit_ack = hs_buf_in_commit_ack;
        buf_out_q         = hs_buf_out_q;
        buf_out_len       = hs_buf_out_len;
        buf_out_hasdata   = hs_buf_out_hasdata;
        buf_out_arm_ack   = hs_buf_out_arm_ack;
        vend_req_act      = hs_vend_req_act;
        vend_req_request  = hs_vend_req_request;
        vend_req_val      = hs_vend_req_val;
      end
      default: ;
    endcase
    // Draining: let acks through but stop the app from starting new work
    if (state_q == DRAIN) begin
      buf_in_ready    = 1'b0;
      buf_out_hasdata = 1'b0;
    end
  end

  assign cpend_d  = (cpend_q | (routed & buf_in_commit)) & ~buf_in_commit_ack;
  assign apend_d  = (apend_q | (routed & buf_out_arm)) & ~buf_out_arm_ack;
  assign lost     = cpend_d | apend_d;
  assign old_qual = sel_hs ? hs_qual_q : ss_qual_q;
  assign tgt_state = (tgt_q == SEL_SS) ? ACT_SS :
                     (tgt_q == SEL_HS) ? ACT_HS : IDLE;

  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tgt_q         <= SEL_NONE;
      link_sel_q    <= SEL_NONE;
      link_switch_q <= 1'b0;
      xfer_abort_q  <= 1'b0;
      timer_q       <= '0;
      cpend_q       <= 1'b0;
      apend_q       <= 1'b0;
    end else begin
      link_switch_q <= 1'b0;
      xfer_abort_q  <= 1'b0;
      cpend_q       <= cpend_d;
      apend_q       <= apend_d;
      unique case (state_q)
        IDLE: begin
          if (ss_qual_q) begin
            state_q       <= ACT_SS;
            link_sel_q    <= SEL_SS;
            link_switch_q <= 1'b1;
          end else if (hs_qual_q) begin
            state_q       <= ACT_HS;
            link_sel_q    <= SEL_HS;
            link_switch_q <= 1'b1;
          end
        end
        ACT_HS: begin
          if (!hs_qual_q) begin
            state_q       <= IDLE;
            link_sel_q    <= SEL_NONE;
            link_switch_q <= 1'b1;
            xfer_abort_q  <= lost;
            cpend_q       <= 1'b0;
            apend_q       <= 1'b0;
          end else if (ss_qual_q && PREFER_SS != 0) begin
            state_q <= DRAIN;
            tgt_q   <= SEL_SS;
            timer_q <= '0;
          end
        end
        ACT_SS: begin
          if (!ss_qual_q) begin
            state_q       <= IDLE;
            link_sel_q    <= SEL_NONE;
            link_switch_q <= 1'b1;
            xfer_abort_q  <= lost;
            cpend_q       <= 1'b0;
            apend_q       <= 1'b0;
          end
        end
        DRAIN: begin
          if (!old_qual) begin
            state_q       <= IDLE;
            link_sel_q    <= SEL_NONE;
            link_switch_q <= 1'b1;
            xfer_abort_q  <= lost;
            cpend_q       <= 1'b0;
            apend_q       <= 1'b0;
          end else if (!(cpend_q | apend_q) || (timer_q == T_MAX && lost)) begin
            // An ack landing on the timeout cycle clears pending; switch next edge
            state_q       <= tgt_state;
            link_sel_q    <= tgt_q;
            link_switch_q <= 1'b1;
            xfer_abort_q  <= lost;
            cpend_q       <= 1'b0;
            apend_q       <= 1'b0;
          end else if (timer_q != T_MAX) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_link_arbiter.sv
// Directed bench for usb_link_arbiter with a write-data scoreboard.
// A second instance with PREFER_SS=0 shares all inputs.
module tb_usb_link_arbiter;
  localparam int AW = 9, DW = 8, LW = 10;

  logic ext_clk = 1'b0, reset = 1'b1;
  logic ss_connected = 1'b0, hs_connected = 1'b0;
  logic [AW-1:0] buf_in_addr = '0, buf_out_addr = '0;
  logic [DW-1:0] buf_in_data = '0;
  logic buf_in_wren = 1'b0, buf_in_commit = 1'b0, buf_out_arm = 1'b0;
  logic [LW-1:0] buf_in_commit_len = '0;

  logic ss_rdy = 1'b1, ss_cack = 1'b0, ss_hd = 1'b1, ss_aack = 1'b0, ss_va = 1'b1;
  logic hs_rdy = 1'b1, hs_cack = 1'b0, hs_hd = 1'b1, hs_aack = 1'b0, hs_va = 1'b1;
  logic [DW-1:0] ss_q = 8'h5A, hs_q = 8'hA5;
  logic [LW-1:0] ss_len = 10'd100, hs_len = 10'd200;
  logic [7:0] ss_vr = 8'h11, hs_vr = 8'h22;
  logic [15:0] ss_vv = 16'h5678, hs_vv = 16'h1234;

  logic buf_in_ready, buf_in_commit_ack, buf_out_hasdata, buf_out_arm_ack;
  logic [DW-1:0] buf_out_q;
  logic [LW-1:0] buf_out_len;
  logic vend_req_act;
  logic [7:0] vend_req_request;
  logic [15:0] vend_req_val;
  logic [AW-1:0] ss_ia, hs_ia, ss_oa, hs_oa;
  logic [DW-1:0] ss_id, hs_id;
  logic ss_iw, hs_iw, ss_ic, hs_ic, ss_arm, hs_arm;
  logic [LW-1:0] ss_il, hs_il;
  logic [1:0] link_sel;
  logic link_switch, xfer_abort;

  logic d0_rdy, d0_cack, d0_hd, d0_aack, d0_va;
  logic [DW-1:0] d0_q;
  logic [LW-1:0] d0_len;
  logic [7:0] d0_vr;
  logic [15:0] d0_vv;
  logic [AW-1:0] d0_ss_ia, d0_hs_ia, d0_ss_oa, d0_hs_oa;
  logic [DW-1:0] d0_ss_id, d0_hs_id;
  logic d0_ss_iw, d0_hs_iw, d0_ss_ic, d0_hs_ic, d0_ss_arm, d0_hs_arm;
  logic [LW-1:0] d0_ss_il, d0_hs_il;
  logic [1:0] d0_sel;
  logic d0_sw, d0_ab;

  always #5 ext_clk = ~ext_clk;

  usb_link_arbiter #(.DEBOUNCE_CYC(16), .DRAIN_TO(64), .PREFER_SS(1)) dut (
    .ext_clk(ext_clk), .reset(reset),
    .ss_connected(ss_connected), .hs_connected(hs_connected),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
    .buf_in_wren(buf_in_wren), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len),
    .buf_in_ready(buf_in_ready), .buf_in_commit_ack(buf_in_commit_ack),
    .buf_out_addr(buf_out_addr), .buf_out_arm(buf_out_arm),
    .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_arm_ack(buf_out_arm_ack),
    .vend_req_act(vend_req_act), .vend_req_request(vend_req_request),
    .vend_req_val(vend_req_val),
    .ss_buf_in_addr(ss_ia), .ss_buf_in_data(ss_id), .ss_buf_in_wren(ss_iw),
    .ss_buf_in_commit(ss_ic), .ss_buf_in_commit_len(ss_il),
    .hs_buf_in_addr(hs_ia), .hs_buf_in_data(hs_id), .hs_buf_in_wren(hs_iw),
    .hs_buf_in_commit(hs_ic), .hs_buf_in_commit_len(hs_il),
    .ss_buf_out_addr(ss_oa), .hs_buf_out_addr(hs_oa),
    .ss_buf_out_arm(ss_arm), .hs_buf_out_arm(hs_arm),
    .ss_buf_in_ready(ss_rdy), .ss_buf_in_commit_ack(ss_cack),
    .ss_buf_out_q(ss_q), .ss_buf_out_len(ss_len),
    .ss_buf_out_hasdata(ss_hd), .ss_buf_out_arm_ack(ss_aack),
    .ss_vend_req_act(ss_va), .ss_vend_req_request(ss_vr),
    .ss_vend_req_val(ss_vv),
    .hs_buf_in_ready(hs_rdy), .hs_buf_in_commit_ack(hs_cack),
    .hs_buf_out_q(hs_q), .hs_buf_out_len(hs_len),
    .hs_buf_out_hasdata(hs_hd), .hs_buf_out_arm_ack(hs_aack),
    .hs_vend_req_act(hs_va), .hs_vend_req_request(hs_vr),
    .hs_vend_req_val(hs_vv),
    .link_sel(link_sel), .link_switch(link_switch), .xfer_abort(xfer_abort)
  );

  usb_link_arbiter #(.DEBOUNCE_CYC(16), .DRAIN_TO(64), .PREFER_SS(0)) dut0 (
    .ext_clk(ext_clk), .reset(reset),
    .ss_connected(ss_connected), .hs_connected(hs_connected),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data),
    .buf_in_wren(buf_in_wren), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len),
    .buf_in_ready(d0_rdy), .buf_in_commit_ack(d0_cack),
    .buf_out_addr(buf_out_addr), .buf_out_arm(buf_out_arm),
    .buf_out_q(d0_q), .buf_out_len(d0_len),
    .buf_out_hasdata(d0_hd), .buf_out_arm_ack(d0_aack),
    .vend_req_act(d0_va), .vend_req_request(d0_vr),
    .vend_req_val(d0_vv),
    .ss_buf_in_addr(d0_ss_ia), .ss_buf_in_data(d0_ss_id),
    .ss_buf_in_wren(d0_ss_iw), .ss_buf_in_commit(d0_ss_ic),
    .ss_buf_in_commit_len(d0_ss_il),
    .hs_buf_in_addr(d0_hs_ia), .hs_buf_in_data(d0_hs_id),
    .hs_buf_in_wren(d0_hs_iw), .hs_buf_in_commit(d0_hs_ic),
    .hs_buf_in_commit_len(d0_hs_il),
    .ss_buf_out_addr(d0_ss_oa), .hs_buf_out_addr(d0_hs_oa),
    .ss_buf_out_arm(d0_ss_arm), .hs_buf_out_arm(d0_hs_arm),
    .ss_buf_in_ready(ss_rdy), .ss_buf_in_commit_ack(ss_cack),
    .ss_buf_out_q(ss_q), .ss_buf_out_len(ss_len),
    .ss_buf_out_hasdata(ss_hd), .ss_buf_out_arm_ack(ss_aack),
    .ss_vend_req_act(ss_va), .ss_vend_req_request(ss_vr),
    .ss_vend_req_val(ss_vv),
    .hs_buf_in_ready(hs_rdy), .hs_buf_in_commit_ack(hs_cack),
    .hs_buf_out_q(hs_q), .hs_buf_out_len(hs_len),
    .hs_buf_out_hasdata(hs_hd), .hs_buf_out_arm_ack(hs_aack),
    .hs_vend_req_act(hs_va), .hs_vend_req_request(hs_vr),
    .hs_vend_req_val(hs_vv),
    .link_sel(d0_sel), .link_switch(d0_sw), .xfer_abort(d0_ab)
  );

  int passed = 0;
  int total  = 0;
  int abort_cnt = 0;
  logic [DW-1:0] exp_q[$];

  always @(posedge ext_clk)
    if (xfer_abort) abort_cnt <= abort_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge ext_clk);
    #1;
  endtask

  initial begin
    logic any_sel;
    logic [DW-1:0] d, e;
    step(2);
    chk("rst_sel", link_sel, 2'b00);
    chk("rst_sw", link_switch, 1'b0);
    chk("rst_abort", xfer_abort, 1'b0);
    chk("rst_ready", buf_in_ready, 1'b0);
    chk("rst_vval", vend_req_val, 16'h0);
    chk("rst_hs_arm", hs_arm, 1'b0);

    reset = 1'b0;
    any_sel = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) hs_connected = ~hs_connected;
      step(1);
      any_sel = any_sel | (link_sel != 2'b00) | link_switch;
    end
    chk("toggle_no_link", any_sel, 1'b0);

    hs_connected = 1'b0;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    hs_connected = 1'b1;
    step(16);
    chk("hs_sel_e16", link_sel, 2'b00);
    step(1);
    chk("hs_sel_e17", link_sel, 2'b01);
    chk("hs_switch", link_switch, 1'b1);
    chk("d0_hs_sel", d0_sel, 2'b01);
    step(1);
    chk("hs_switch_end", link_switch, 1'b0);
    chk("hs_ready", buf_in_ready, 1'b1);
    chk("hs_outq", buf_out_q, 8'hA5);
    chk("hs_vval", vend_req_val, 16'h1234);

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      buf_in_wren = 1'b1;
      buf_in_data = d;
      buf_in_addr = 9'(i + 3);
      exp_q.push_back(d);
      #1;
      if (hs_iw) begin
        e = exp_q.pop_front();
        chk("hs_wdata", hs_id, e);
      end else begin
        chk("hs_wren", hs_iw, 1'b1);
      end
      chk("ss_wren", ss_iw, 1'b0);
      chk("hs_waddr", hs_ia, 9'(i + 3));
      step(1);
    end
    buf_in_wren = 1'b0;
    chk("sb_empty", exp_q.size(), 0);

    buf_in_commit = 1'b1;
    step(1);
    buf_in_commit = 1'b0;
    ss_connected = 1'b1;
    step(16);
    chk("pre_drain_sel", link_sel, 2'b01);
    chk("pre_drain_rdy", buf_in_ready, 1'b1);
    step(1);
    chk("drain_rdy", buf_in_ready, 1'b0);
    chk("drain_hd", buf_out_hasdata, 1'b0);
    chk("drain_sel", link_sel, 2'b01);
    step(4);
    hs_cack = 1'b1;
    #1;
    chk("drain_ack", buf_in_commit_ack, 1'b1);
    step(1);
    hs_cack = 1'b0;
    chk("ack_edge_sel", link_sel, 2'b01);
    step(1);
    chk("ss_sel", link_sel, 2'b10);
    chk("ss_switch", link_switch, 1'b1);
    chk("ss_no_abort", xfer_abort, 1'b0);
    chk("ss_outq", buf_out_q, 8'h5A);
    chk("d0_keep_hs", d0_sel, 2'b01);
    chk("abort_cnt0", abort_cnt, 0);

    hs_connected = 1'b0;
    step(1);
    chk("d0_k", d0_sel, 2'b01);
    step(1);
    chk("d0_idle", d0_sel, 2'b00);
    step(1);
    chk("d0_ss", d0_sel, 2'b10);
    chk("ss_stays", link_sel, 2'b10);

    buf_out_arm = 1'b1;
    #1;
    chk("ss_arm", ss_arm, 1'b1);
    chk("hs_arm", hs_arm, 1'b0);
    step(1);
    buf_out_arm = 1'b0;
    ss_connected = 1'b0;
    step(1);
    chk("disc_k", link_sel, 2'b10);
    step(1);
    chk("disc_sel", link_sel, 2'b00);
    chk("disc_abort", xfer_abort, 1'b1);
    chk("disc_outq", buf_out_q, 8'h00);
    chk("disc_rdy", buf_in_ready, 1'b0);
    chk("disc_vact", vend_req_act, 1'b0);
    chk("disc_vval", vend_req_val, 16'h0);
    step(1);
    chk("disc_abort_end", xfer_abort, 1'b0);
    chk("abort_cnt1", abort_cnt, 1);

    hs_connected = 1'b1;
    step(17);
    chk("to_hs_sel", link_sel, 2'b01);
    buf_in_commit = 1'b1;
    step(1);
    buf_in_commit = 1'b0;
    ss_connected = 1'b1;
    step(17);
    chk("to_drain_rdy", buf_in_ready, 1'b0);
    step(63);
    chk("to_sel_63", link_sel, 2'b01);
    chk("to_abort_63", xfer_abort, 1'b0);
    step(1);
    chk("to_sel_64", link_sel, 2'b10);
    chk("to_abort", xfer_abort, 1'b1);
    step(1);
    chk("to_abort_end", xfer_abort, 1'b0);
    chk("abort_cnt2", abort_cnt, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
